// File: rtl/countdown_timer.sv
// countdown_timer: BCD h:mm:ss countdown with load/start/stop control, 1-cycle tick-to-digit latency.
// Optional COUNTDOWN_AUTORELOAD_EN: reaching zero reloads the preset and keeps running instead of expiring.
module countdown_timer #(
   parameter int unsigned HOUR_MAX = 9
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       load,
   input  logic [3:0] ps0,
   input  logic [3:0] ps1,
   input  logic [3:0] pm0,
   input  logic [3:0] pm1,
   input  logic [3:0] ph,
   input  logic       start,
   input  logic       stop,
   output logic [3:0] s0,
   output logic [3:0] s1,
   output logic [3:0] m0,
   output logic [3:0] m1,
   output logic [3:0] h,
   output logic       running,
   output logic       expired,
   output logic       done_pulse
);

   typedef enum logic [1:0] {IDLE, READY, RUN, EXPIRED} state_t;

   localparam logic [3:0] H_MAX = 4'(HOUR_MAX);

   function automatic logic [3:0] clamp(input logic [3:0] d, input logic [3:0] mx);
      return (d > mx) ? mx : d;
   endfunction

   state_t     state_q, state_d;
   logic [3:0] s0_q, s0_d, s1_q, s1_d, m0_q, m0_d, m1_q, m1_d, h_q, h_d;
   logic [3:0] dec_s0, dec_s1, dec_m0, dec_m1, dec_h;
   logic [3:0] cl_s0, cl_s1, cl_m0, cl_m1, cl_h;
   logic       done_q, done_d;
   logic       running_q, expired_q;
   logic       cur_zero, dec_zero;
`ifdef COUNTDOWN_AUTORELOAD_EN
   // Only the reload path reads the preset, so it is built only with that path.
   logic [19:0] pre_q, pre_d;
`endif

   assign cl_s0 = clamp(ps0, 4'd9);
   assign cl_s1 = clamp(ps1, 4'd5);
   assign cl_m0 = clamp(pm0, 4'd9);
   assign cl_m1 = clamp(pm1, 4'd5);
   assign cl_h  = clamp(ph, H_MAX);

   assign cur_zero = (s0_q == 4'd0) && (s1_q == 4'd0) && (m0_q == 4'd0) &&
                     (m1_q == 4'd0) && (h_q == 4'd0);
   assign dec_zero = (dec_s0 == 4'd0) && (dec_s1 == 4'd0) && (dec_m0 == 4'd0) &&
                     (dec_m1 == 4'd0) && (dec_h == 4'd0);

   // One-second borrow chain; only evaluated in RUN where the value is nonzero.
   always_comb begin
      dec_s0 = s0_q;
      dec_s1 = s1_q;
      dec_m0 = m0_q;
      dec_m1 = m1_q;
      dec_h  = h_q;
      if (s0_q != 4'd0) begin
         dec_s0 = s0_q - 4'd1;
      end else begin
         dec_s0 = 4'd9;
         if (s1_q != 4'd0) begin
            dec_s1 = s1_q - 4'd1;
         end else begin
            dec_s1 = 4'd5;
            if (m0_q != 4'd0) begin
               dec_m0 = m0_q - 4'd1;
            end else begin
               dec_m0 = 4'd9;
               if (m1_q != 4'd0) begin
                  dec_m1 = m1_q - 4'd1;
               end else begin
                  dec_m1 = 4'd5;
                  dec_h  = h_q - 4'd1;
               end
            end
         end
      end
   end

   // Strict priority: load, then stop, then start, then tick; a lower strobe is dropped.
   always_comb begin
      state_d = state_q;
      s0_d    = s0_q;
      s1_d    = s1_q;
      m0_d    = m0_q;
      m1_d    = m1_q;
      h_d     = h_q;
      done_d  = 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
      pre_d   = pre_q;
`endif
      if (load) begin
         state_d = READY;
         s0_d    = cl_s0;
         s1_d    = cl_s1;
         m0_d    = cl_m0;
         m1_d    = cl_m1;
         h_d     = cl_h;
`ifdef COUNTDOWN_AUTORELOAD_EN
         pre_d   = {cl_h, cl_m1, cl_m0, cl_s1, cl_s0};
`endif
      end else if (stop) begin
         if (state_q == RUN) state_d = READY;
      end else if (start) begin
         if ((state_q == READY) && !cur_zero) state_d = RUN;
      end else if (tick && (state_q == RUN)) begin
         s0_d   = dec_s0;
         s1_d   = dec_s1;
         m0_d   = dec_m0;
         m1_d   = dec_m1;
         h_d    = dec_h;
         done_d = dec_zero;
         if (dec_zero) begin
`ifdef COUNTDOWN_AUTORELOAD_EN
            {h_d, m1_d, m0_d, s1_d, s0_d} = pre_q;
`else
            state_d = EXPIRED;
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         s0_q      <= 4'd0;
         s1_q      <= 4'd0;
         m0_q      <= 4'd0;
         m1_q      <= 4'd0;
         h_q       <= 4'd0;
         done_q    <= 1'b0;
         running_q <= 1'b0;
         expired_q <= 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
         pre_q     <= 20'd0;
`endif
      end else begin
         state_q   <= state_d;
         s0_q      <= s0_d;
         s1_q      <= s1_d;
         m0_q      <= m0_d;
         m1_q      <= m1_d;
         h_q       <= h_d;
         done_q    <= done_d;
         running_q <= (state_d == RUN);
         expired_q <= (state_d == EXPIRED);
`ifdef COUNTDOWN_AUTORELOAD_EN
         pre_q     <= pre_d;
`endif
      end
   end

   assign s0         = s0_q;
   assign s1         = s1_q;
   assign m0         = m0_q;
   assign m1         = m1_q;
   assign h          = h_q;
   assign running    = running_q;
   assign expired    = expired_q;
   assign done_pulse = done_q;

endmodule
